pic_host_interface: RTL and testbench
=====================================

Name: pic_host_interface

Overview:
CPU-side bus master that sits at the other end of the PIC_8259 pins. It programs the PIC through the CS/WR/A0/D write port with an ICW/OCW sequence. It answers INT with an 8086-mode two-pulse INTA cycle, captures the vector byte and hands it to the core. It issues a non-specific EOI (OCW2) on request.

Parameters:
T_PULSE, 2, cycles WR or INTA is held low per strobe (>=1)
T_GAP, 1, cycles INTA is held high between the two INTA pulses (>=1)
ICW1_VAL, 8'h13, edge-triggered, single PIC, ICW4 needed
ICW2_VAL, 8'h20, vector base
ICW4_VAL, 8'h01, 8086 mode, normal EOI
OCW1_VAL, 8'h00, IMR value written at end of init (all IR enabled)

Ports:
CLK  in  1  single clock, all state on rising edge
RST_N  in  1  asynchronous, active-low reset
INIT_START  in  1  pulse: run init sequence
INIT_DONE  out  1  high once init sequence has completed
INT  in  1  PIC interrupt request
VEC_VALID  out  1  captured vector available
VEC  out  8  captured vector byte
VEC_ACK  in  1  core consumed vector
EOI_REQ  in  1  pulse: send non-specific EOI
EOI_DONE  out  1  one-cycle pulse when EOI write completes
CS  out  1  PIC chip select, active low
WR  out  1  PIC write strobe, active low
RD  out  1  PIC read strobe, active low; tied high (1)
A0  out  1  PIC register select
D_OUT  out  8  data driven to PIC
D_OE  out  1  D_OUT drive enable (top-level tristate)
D_IN  in  8  data bus from PIC
INTA  out  1  interrupt acknowledge, active low
BUSY  out  1  FSM not in IDLE

Behaviour:
- Reset values: CS=1, WR=1, RD=1, INTA=1, A0=0, D_OUT=0, D_OE=0, INIT_DONE=0, VEC_VALID=0, VEC=0, EOI_DONE=0, BUSY=0. FSM goes to IDLE.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, INTA1, IGAP, INTA2.
- IDLE arbitration, highest priority first: INIT_START, then EOI_REQ (only when INIT_DONE=1), then INT (only when INIT_DONE=1 and VEC_VALID=0).
- Each write cycle:
  - W_SETUP, 1 cycle: CS=0, A0 and D_OUT valid, D_OE=1, WR=1.
  - W_STROBE, T_PULSE cycles: WR=0.
  - W_HOLD, 1 cycle: WR=1, CS, A0 and D_OE still held.
  - Total per write is T_PULSE+2 cycles.
- Init sequence, back-to-back writes:
  - ICW1 (A0=0), ICW2 (A0=1), ICW4 (A0=1), OCW1 (A0=1).
  - A write index register (0..3) selects the value.
  - INIT_START clears INIT_DONE in the next cycle.
  - INIT_DONE is set in the cycle after the last W_HOLD.
- EOI: one write, OCW2=8'h20, A0=0. EOI_DONE pulses for one cycle in the cycle after W_HOLD.
- INTA cycle:
  - INTA1: INTA=0 for T_PULSE cycles.
  - IGAP: INTA=1 for T_GAP cycles.
  - INTA2: INTA=0 for T_PULSE cycles.
  - D_IN is sampled on the last INTA2 cycle. In the next cycle VEC is loaded, VEC_VALID=1 and INTA=1.
  - CS stays 1 and D_OE stays 0 throughout.
- VEC_VALID holds until VEC_ACK is sampled high, then clears. VEC is held stable while VEC_VALID=1.
- INT deasserting mid-cycle: the cycle completes and the byte is returned (the PIC supplies the spurious IR7 vector).
- Request pulses arriving while BUSY=1:
  - INIT_START and EOI_REQ are latched into one pending bit each and serviced at the next IDLE.
  - A second pulse while the bit is pending is merged.
- INIT_START while INIT_DONE=1 re-runs the full sequence. INT is not serviced until it completes.
- VEC_ACK together with a new INT in the same cycle: VEC_VALID clears that cycle, and the new INTA cycle may start the following cycle.
- RST_N asserted mid-cycle: all strobes return high immediately (asynchronous). Pending bits clear. INIT_DONE clears.
- Strobe counter width is clog2(max(T_PULSE,T_GAP)+1). It reloads on every state entry.

Decomposition:
- Shared package pic_pkg holds:
  - state enum;
  - OCW2_NS_EOI=8'h20;
  - A0 select constants;
  - the default ICW values (reused by PIC_8259 tests).
- One sub-module, pic_strobe_timer: loadable down-counter with a done flag, used for the WR and INTA pulse and gap timing.

Test Plan:
1. Reset, then INIT_START pulse. Required:
   - 4 writes of 4 cycles each: D_OUT 13/20/01/00, A0 0/1/1/1, WR low 2 cycles each.
   - INIT_DONE=1 in cycle 17.
2. After init, INT=1 with D_IN=8'h23 during INTA2. Required:
   - INTA low 2 cycles, high 1, low 2.
   - VEC=8'h23 with VEC_VALID=1 in the next cycle; held until VEC_ACK.
3. INT=1 while VEC_VALID=1 with no ACK -> no INTA pulse. Assert VEC_ACK -> second INTA cycle starts within 1 cycle.
4. EOI_REQ pulsed during an INTA cycle -> after VEC_VALID, a write of 8'h20 with A0=0 runs and EOI_DONE pulses once.
5. INT dropped after INTA1, D_IN=8'h27 -> full INTA2 still issued and VEC=8'h27. INT before INIT_DONE -> INTA stays 1.
6. RST_N low during W_STROBE -> WR, CS, INTA=1 and D_OE=0 asynchronously, INIT_DONE=0. After release, BUSY=0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 host-side interface.
// The DEF_* bytes are the default init program, also reused by PIC_8259 tests.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_INTA1    = 3'd4,
    ST_IGAP     = 3'd5,
    ST_INTA2    = 3'd6
  } pic_state_e;

  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  // A0 selects the command port (ICW1/OCW2/OCW3) or the data port (ICW2-4/OCW1).
  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam logic [7:0] DEF_ICW1 = 8'h13;
  localparam logic [7:0] DEF_ICW2 = 8'h20;
  localparam logic [7:0] DEF_ICW4 = 8'h01;
  localparam logic [7:0] DEF_OCW1 = 8'h00;

  localparam logic [1:0] INIT_LAST_IDX = 2'd3;

endpackage

// File: rtl/pic_strobe_timer.sv
// Loadable down-counter timing WR/INTA pulses and the INTA gap.
// load_val is the number of cycles remaining after the load cycle; done is valid in the load cycle.
module pic_strobe_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  assign done = load ? (load_val == '0) : (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? '0 : load_val - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pic_host_interface.sv
// CPU-side master for an 8259: programs it with ICW/OCW writes, runs 8086-mode
// two-pulse INTA cycles to fetch vectors, and issues non-specific EOIs.
module pic_host_interface
  import pic_pkg::*;
#(
  parameter int         T_PULSE  = 2,
  parameter int         T_GAP    = 1,
  parameter logic [7:0] ICW1_VAL = DEF_ICW1,
  parameter logic [7:0] ICW2_VAL = DEF_ICW2,
  parameter logic [7:0] ICW4_VAL = DEF_ICW4,
  parameter logic [7:0] OCW1_VAL = DEF_OCW1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  output logic       init_done,
  input  logic       int_req,
  output logic       vec_valid,
  output logic [7:0] vec,
  input  logic       vec_ack,
  input  logic       eoi_req,
  output logic       eoi_done,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       inta,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] PULSE_LD = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(T_GAP - 1);
  localparam logic [TW-1:0] SINGLE_LD = '0;

  pic_state_e    state;
  logic          init_pend;
  logic          eoi_pend;
  logic [1:0]    wr_idx;
  logic          wr_init;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic init_go;
  logic eoi_go;
  logic int_go;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return ICW1_VAL;
      2'd1:    return ICW2_VAL;
      2'd2:    return ICW4_VAL;
      default: return OCW1_VAL;
    endcase
  endfunction

  pic_strobe_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // A vector being acknowledged this cycle frees the slot, so a new INTA may start at once.
  assign init_go = init_start | init_pend;
  assign eoi_go  = (eoi_req | eoi_pend) & init_done;
  assign int_go  = int_req & init_done & (~vec_valid | vec_ack);

  assign rd        = 1'b1;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cs        <= 1'b1;
      wr        <= 1'b1;
      inta      <= 1'b1;
      a0        <= 1'b0;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      init_done <= 1'b0;
      vec_valid <= 1'b0;
      vec       <= 8'h00;
      eoi_done  <= 1'b0;
      init_pend <= 1'b0;
      eoi_pend  <= 1'b0;
      wr_idx    <= 2'd0;
      wr_init   <= 1'b0;
      tmr_load  <= 1'b0;
      tmr_val   <= '0;
    end else begin
      eoi_done <= 1'b0;
      tmr_load <= 1'b0;

      if (vec_valid && vec_ack) vec_valid <= 1'b0;

      if (state != ST_IDLE) begin
        if (init_start) init_pend <= 1'b1;
        if (eoi_req)    eoi_pend  <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (init_go) begin
            init_pend <= 1'b0;
            init_done <= 1'b0;
            if (eoi_req) eoi_pend <= 1'b1;
            wr_init  <= 1'b1;
            wr_idx   <= 2'd0;
            cs       <= 1'b0;
            a0       <= A0_CMD;
            d_out    <= init_byte(2'd0);
            d_oe     <= 1'b1;
            state    <= ST_W_SETUP;
            tmr_load <= 1'b1;
            tmr_val  <= SINGLE_LD;
          end else if (eoi_go) begin
            eoi_pend <= 1'b0;
            wr_init  <= 1'b0;
            cs       <= 1'b0;
            a0       <= A0_CMD;
            d_out    <= OCW2_NS_EOI;
            d_oe     <= 1'b1;
            state    <= ST_W_SETUP;
            tmr_load <= 1'b1;
            tmr_val  <= SINGLE_LD;
          end else if (int_go) begin
            inta     <= 1'b0;
            state    <= ST_INTA1;
            tmr_load <= 1'b1;
            tmr_val  <= PULSE_LD;
          end
        end

        ST_W_SETUP: begin
          wr       <= 1'b0;
          state    <= ST_W_STROBE;
          tmr_load <= 1'b1;
          tmr_val  <= PULSE_LD;
        end

        ST_W_STROBE: begin
          if (tmr_done) begin
            wr       <= 1'b1;
            state    <= ST_W_HOLD;
            tmr_load <= 1'b1;
            tmr_val  <= SINGLE_LD;
          end
        end

        ST_W_HOLD: begin
          if (wr_init && (wr_idx != INIT_LAST_IDX)) begin
            // Init writes run back to back: CS and D_OE stay asserted across them.
            wr_idx   <= wr_idx + 2'd1;
            a0       <= A0_DATA;
            d_out    <= init_byte(wr_idx + 2'd1);
            state    <= ST_W_SETUP;
            tmr_load <= 1'b1;
            tmr_val  <= SINGLE_LD;
          end else begin
            cs    <= 1'b1;
            d_oe  <= 1'b0;
            a0    <= 1'b0;
            d_out <= 8'h00;
            state <= ST_IDLE;
            if (wr_init) init_done <= 1'b1;
            else         eoi_done  <= 1'b1;
          end
        end

        ST_INTA1: begin
          if (tmr_done) begin
            inta     <= 1'b1;
            state    <= ST_IGAP;
            tmr_load <= 1'b1;
            tmr_val  <= GAP_LD;
          end
        end

        ST_IGAP: begin
          if (tmr_done) begin
            inta     <= 1'b0;
            state    <= ST_INTA2;
            tmr_load <= 1'b1;
            tmr_val  <= PULSE_LD;
          end
        end

        ST_INTA2: begin
          // The byte is captured even if INT has dropped; the PIC then returns its IR7 vector.
          if (tmr_done) begin
            inta      <= 1'b1;
            vec       <= d_in;
            vec_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_interface.sv
// Directed bench for pic_host_interface: init program, INTA cycles, EOI,
// dropped INT, INT before init, and asynchronous reset mid-write.
module tb_pic_host_interface;

  logic       clk;
  logic       rst_n;
  logic       init_start;
  logic       init_done;
  logic       int_req;
  logic       vec_valid;
  logic [7:0] vec;
  logic       vec_ack;
  logic       eoi_req;
  logic       eoi_done;
  logic       cs;
  logic       wr;
  logic       rd;
  logic       a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;
  logic       inta;
  logic       busy;
  logic [2:0] dbg_state;

  int n_tests;
  int n_fail;

  pic_host_interface dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_done  (init_done),
    .int_req    (int_req),
    .vec_valid  (vec_valid),
    .vec        (vec),
    .vec_ack    (vec_ack),
    .eoi_req    (eoi_req),
    .eoi_done   (eoi_done),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .a0         (a0),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .d_in       (d_in),
    .inta       (inta),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_d  [4];
    logic       exp_a0 [4];
    logic       exp_inta [5];

    exp_d    = '{8'h13, 8'h20, 8'h01, 8'h00};
    exp_a0   = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_inta = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_tests  = 0;
    n_fail   = 0;

    rst_n = 1'b0; init_start = 1'b0; int_req = 1'b0; vec_ack = 1'b0;
    eoi_req = 1'b0; d_in = 8'h00;
    step();
    step();

    // Reset values
    check("rst_cs", cs, 1);
    check("rst_wr", wr, 1);
    check("rst_rd", rd, 1);
    check("rst_inta", inta, 1);
    check("rst_a0", a0, 0);
    check("rst_d_out", d_out, 8'h00);
    check("rst_d_oe", d_oe, 0);
    check("rst_init_done", init_done, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_vec", vec, 8'h00);
    check("rst_eoi_done", eoi_done, 0);
    check("rst_busy", busy, 0);

    rst_n = 1'b1;
    step();

    // Init program: four 4-cycle writes, INIT_DONE in cycle 17
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check($sformatf("init%0d_setup_cs", w), cs, 0);
      check($sformatf("init%0d_setup_wr", w), wr, 1);
      check($sformatf("init%0d_setup_oe", w), d_oe, 1);
      check($sformatf("init%0d_a0", w), a0, exp_a0[w]);
      check($sformatf("init%0d_d_out", w), d_out, exp_d[w]);
      check($sformatf("init%0d_busy", w), busy, 1);
      step();
      for (int p = 0; p < 2; p++) begin
        check($sformatf("init%0d_strobe%0d_wr", w, p), wr, 0);
        check($sformatf("init%0d_strobe%0d_d_out", w, p), d_out, exp_d[w]);
        step();
      end
      check($sformatf("init%0d_hold_wr", w), wr, 1);
      check($sformatf("init%0d_hold_cs", w), cs, 0);
      check($sformatf("init%0d_hold_oe", w), d_oe, 1);
      check($sformatf("init%0d_hold_a0", w), a0, exp_a0[w]);
      check($sformatf("init%0d_done_low", w), init_done, 0);
      step();
    end
    check("init_done_c17", init_done, 1);
    check("init_idle_cs", cs, 1);
    check("init_idle_oe", d_oe, 0);
    check("init_idle_busy", busy, 0);

    // INTA cycle returning 8'h23
    int_req = 1'b1;
    d_in    = 8'h23;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("inta1_c%0d", c), inta, exp_inta[c]);
      check($sformatf("inta1_cs_c%0d", c), cs, 1);
      check($sformatf("inta1_oe_c%0d", c), d_oe, 0);
      step();
    end
    check("vec_23", vec, 8'h23);
    check("vec_valid_23", vec_valid, 1);
    check("vec_inta_high", inta, 1);

    // INT held while the vector is unacknowledged: no new INTA
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("blocked_inta_c%0d", c), inta, 1);
      check($sformatf("blocked_valid_c%0d", c), vec_valid, 1);
      check($sformatf("blocked_vec_c%0d", c), vec, 8'h23);
    end

    // ACK with INT still high: new INTA starts the next cycle; EOI requested mid-cycle
    vec_ack = 1'b1;
    d_in    = 8'h31;
    step();
    vec_ack = 1'b0;
    check("ack_valid_clr", vec_valid, 0);
    check("ack_inta_restart", inta, 0);
    int_req = 1'b0;
    eoi_req = 1'b1;
    step();
    eoi_req = 1'b0;
    check("inta2_c1", inta, 0);
    step();
    check("inta2_gap", inta, 1);
    step();
    check("inta2_c3", inta, 0);
    step();
    check("inta2_c4", inta, 0);
    check("inta2_no_eoi_yet", cs, 1);
    step();
    check("vec_31", vec, 8'h31);
    check("vec_valid_31", vec_valid, 1);

    // Pending EOI write: OCW2 8'h20 on A0=0
    step();
    check("eoi_setup_cs", cs, 0);
    check("eoi_setup_a0", a0, 0);
    check("eoi_setup_d", d_out, 8'h20);
    check("eoi_setup_oe", d_oe, 1);
    check("eoi_setup_wr", wr, 1);
    step();
    check("eoi_strobe0_wr", wr, 0);
    step();
    check("eoi_strobe1_wr", wr, 0);
    step();
    check("eoi_hold_wr", wr, 1);
    check("eoi_hold_cs", cs, 0);
    check("eoi_hold_done", eoi_done, 0);
    step();
    check("eoi_done_pulse", eoi_done, 1);
    check("eoi_end_cs", cs, 1);
    check("eoi_end_busy", busy, 0);
    step();
    check("eoi_done_once", eoi_done, 0);
    check("eoi_vec_held", vec, 8'h31);
    check("eoi_valid_held", vec_valid, 1);

    vec_ack = 1'b1;
    step();
    vec_ack = 1'b0;
    check("ack2_valid_clr", vec_valid, 0);
    check("ack2_no_inta", inta, 1);

    // INT dropped after INTA1: the cycle still completes and returns 8'h27
    int_req = 1'b1;
    d_in    = 8'h27;
    step();
    check("drop_inta_c0", inta, 0);
    step();
    check("drop_inta_c1", inta, 0);
    int_req = 1'b0;
    step();
    check("drop_gap", inta, 1);
    step();
    check("drop_inta2_c0", inta, 0);
    step();
    check("drop_inta2_c1", inta, 0);
    step();
    check("drop_vec", vec, 8'h27);
    check("drop_valid", vec_valid, 1);
    vec_ack = 1'b1;
    step();
    vec_ack = 1'b0;

    // Re-run init, then assert reset asynchronously during W_STROBE
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check("rerun_done_clr", init_done, 0);
    check("rerun_setup_cs", cs, 0);
    step();
    check("rerun_strobe_wr", wr, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_wr", wr, 1);
    check("async_cs", cs, 1);
    check("async_inta", inta, 1);
    check("async_oe", d_oe, 0);
    check("async_init_done", init_done, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_init_done", init_done, 0);

    // INT before init completes is ignored
    int_req = 1'b1;
    d_in    = 8'h55;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("noinit_inta_c%0d", c), inta, 1);
      check($sformatf("noinit_busy_c%0d", c), busy, 0);
    end
    int_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
